// File: rtl/bram_read_arbiter.sv
// Two-requester read arbiter for a single-port frame-buffer BRAM, with a tag pipeline
// that routes each returned word back to its issuer. Optional burst locking: BRAM_ARB_BURST_EN.
module bram_read_arbiter #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int BURST_LEN    = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [1:0]              req_valid_in,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_in,
  output logic [1:0]              req_ready_out,
  output logic [1:0]              rsp_valid_out,
  output logic [DATA_WIDTH-1:0]   rsp_data_out,
  output logic [ADDR_WIDTH-1:0]   bram_addr_out,
  output logic                    bram_en_out,
  input  logic [DATA_WIDTH-1:0]   bram_dout_in,
  output logic                    busy_out
);

`ifdef BRAM_ARB_BURST_EN
  localparam int BURST_EFF = BURST_LEN;
`else
  // Without burst locking the run length collapses to one beat (plain round-robin).
  localparam int BURST_EFF = (BURST_LEN < 1) ? BURST_LEN : 1;
`endif
  localparam int CW = (BURST_EFF > 1) ? $clog2(BURST_EFF) : 1;
  localparam logic [CW:0] BURST_MAX = (CW+1)'(BURST_EFF);

  logic                    last_grant;
  logic [CW-1:0]           burst_cnt;
  logic [CW-1:0]           cnt_base;
  logic [CW:0]             cnt_inc;
  logic [CW-1:0]           burst_next;
  logic                    lock;
  logic                    accept;
  logic                    grant_idx;
  logic                    issue_tag;
  logic [READ_LATENCY-1:0] tag_vld;
  logic [READ_LATENCY-1:0] tag_id;

  // A non-zero count means last_grant was accepted last cycle and its run is not used up.
  assign lock = (burst_cnt != '0);

  always_comb begin
    req_ready_out = 2'b00;
    if (!rst_in) begin
      case (req_valid_in)
        2'b01:   req_ready_out = 2'b01;
        2'b10:   req_ready_out = 2'b10;
        2'b11: begin
          if (lock) req_ready_out[last_grant]  = 1'b1;
          else      req_ready_out[~last_grant] = 1'b1;
        end
        default: req_ready_out = 2'b00;
      endcase
    end
  end

  assign accept    = |req_ready_out;
  assign grant_idx = req_ready_out[1];

  always_comb begin
    cnt_base   = (grant_idx == last_grant) ? burst_cnt : '0;
    cnt_inc    = {1'b0, cnt_base} + (CW+1)'(1);
    burst_next = (cnt_inc == BURST_MAX) ? '0 : cnt_inc[CW-1:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant    <= 1'b1;
      burst_cnt     <= '0;
      bram_en_out   <= 1'b0;
      bram_addr_out <= '0;
      issue_tag     <= 1'b0;
    end else begin
      bram_en_out <= accept;
      if (accept) begin
        bram_addr_out <= grant_idx ? req_addr_in[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : req_addr_in[ADDR_WIDTH-1:0];
        issue_tag     <= grant_idx;
        last_grant    <= grant_idx;
        burst_cnt     <= burst_next;
      end else begin
        burst_cnt     <= '0;
      end
    end
  end

  // Tag pipeline: stage READ_LATENCY-1 is valid in the cycle bram_dout_in carries the word.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_vld       <= '0;
      tag_id        <= '0;
      rsp_valid_out <= 2'b00;
      rsp_data_out  <= '0;
    end else begin
      tag_vld[0] <= bram_en_out;
      tag_id[0]  <= issue_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      rsp_valid_out <= tag_vld[READ_LATENCY-1] ? (tag_id[READ_LATENCY-1] ? 2'b10 : 2'b01)
                                               : 2'b00;
      if (tag_vld[READ_LATENCY-1]) rsp_data_out <= bram_dout_in;
    end
  end

  assign busy_out = bram_en_out | (|tag_vld);

endmodule
